// File: rtl/player_ctrl_pkg.sv
// Shared constants for the player/enemy motion datapath: FSM state codes and direction encoding.
package player_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_RESET  = 3'd0;
  localparam logic [STATE_W-1:0] S_IDLE   = 3'd1;
  localparam logic [STATE_W-1:0] S_SET_L  = 3'd2;
  localparam logic [STATE_W-1:0] S_SET_R  = 3'd3;
  localparam logic [STATE_W-1:0] S_ERASE  = 3'd4;
  localparam logic [STATE_W-1:0] S_UPDATE = 3'd5;
  localparam logic [STATE_W-1:0] S_DRAW   = 3'd6;

  // Direction encoding, also consumed by the bullet spawner.
  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/player_step_clamp.sv
// Combinational one-step move of an X coordinate, clamped to [X_MIN, X_MAX].
module player_step_clamp #(
  parameter int unsigned X_W   = 8,
  parameter int unsigned X_MIN = 0,
  parameter int unsigned X_MAX = 151,
  parameter int unsigned STEP  = 4
) (
  input  logic [X_W-1:0] x_pos,
  input  logic           dir,
  output logic [X_W-1:0] x_next
);
  import player_ctrl_pkg::*;

  // One guard bit keeps both differences and the sum free of wrap-around.
  localparam int unsigned XW1 = X_W + 1;

  logic [X_W:0] x_ext;
  logic [X_W:0] min_ext;
  logic [X_W:0] max_ext;
  logic [X_W:0] step_ext;
  logic [X_W:0] x_wide;

  assign x_ext    = {1'b0, x_pos};
  assign min_ext  = XW1'(X_MIN);
  assign max_ext  = XW1'(X_MAX);
  assign step_ext = XW1'(STEP);

  // Step toward the requested edge, saturating at the bound when the remaining room is under one step.
  always_comb begin
    x_wide = x_ext;
    if (dir == DIR_L) begin
      x_wide = ((x_ext - min_ext) < step_ext) ? min_ext : (x_ext - step_ext);
    end else begin
      x_wide = ((max_ext - x_ext) < step_ext) ? max_ext : (x_ext + step_ext);
    end
    x_next = X_W'(x_wide);
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player ship X movement: samples keys on frame ticks, sequences erase/move/draw with the sprite renderer.
module player_motion_ctrl #(
  parameter int unsigned X_W     = 8,
  parameter int unsigned X_MIN   = 0,
  parameter int unsigned X_MAX   = 151,
  parameter int unsigned X_START = 76,
  parameter int unsigned STEP    = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           left,
  input  logic           right,
  input  logic           frame_tick,
  input  logic           draw_ack,
  output logic [X_W-1:0] x_pos,
  output logic           draw_req,
  output logic           erase,
  output logic           busy,
  output logic           dir
);
  import player_ctrl_pkg::*;

  localparam int unsigned XW1 = X_W + 1;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [X_W-1:0]     x_next;
  logic               can_left;
  logic               can_right;

  assign can_left  = ({1'b0, x_pos} > XW1'(X_MIN));
  assign can_right = ({1'b0, x_pos} < XW1'(X_MAX));

  player_step_clamp #(
    .X_W   (X_W),
    .X_MIN (X_MIN),
    .X_MAX (X_MAX),
    .STEP  (STEP)
  ) u_step_clamp (
    .x_pos  (x_pos),
    .dir    (dir),
    .x_next (x_next)
  );

  // State register; reset parks in S_RESET so the initial draw follows release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; ticks outside S_IDLE fall through unused.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_DRAW;
      S_IDLE: begin
        if (frame_tick) begin
          if (left && !right && can_left) begin
            state_nxt = S_SET_L;
          end else if (right && !left && can_right) begin
            state_nxt = S_SET_R;
          end
        end
      end
      S_SET_L:  state_nxt = S_ERASE;
      S_SET_R:  state_nxt = S_ERASE;
      S_ERASE:  if (draw_ack) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_DRAW;
      S_DRAW:   if (draw_ack) state_nxt = S_IDLE;
      default:  state_nxt = S_RESET;
    endcase
  end

  // Renderer handshake and busy flag decoded from the state register alone.
  always_comb begin
    draw_req = 1'b0;
    erase    = 1'b0;
    busy     = 1'b1;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_ERASE: begin
        draw_req = 1'b1;
        erase    = 1'b1;
      end
      S_DRAW:  draw_req = 1'b1;
      default: ;
    endcase
  end

  // Direction latches on the SET states; position advances only in S_UPDATE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_pos <= X_W'(X_START);
      dir   <= DIR_L;
    end else begin
      case (state)
        S_SET_L:  dir   <= DIR_L;
        S_SET_R:  dir   <= DIR_R;
        S_UPDATE: x_pos <= x_next;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: expected renderer transactions queued by stimulus, checked by a monitor.
module tb_player_motion_ctrl;

  localparam int X_W    = 8;
  localparam int XMIN   = 0;
  localparam int XMAX   = 151;
  localparam int XSTART = 76;
  localparam int STEP   = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           left, right, frame_tick, draw_ack;
  logic [X_W-1:0] x_pos;
  logic           draw_req, erase, busy, dir;

  logic           e_left, e_right, e_tick, e_ack;
  logic [X_W-1:0] e_x;
  logic           e_req, e_erase, e_busy, e_dir;

  typedef struct {
    bit erase;
    int x;
    bit d;
    int hold;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   model_x;
  bit   model_dir;
  int   fixed_delay = -1;
  int   run = 0;
  int   ack_cnt = 0;
  int   ne, nd, ex, dx, n;
  int   pick;
  bit   pl, pr;

  player_motion_ctrl #(
    .X_W(X_W), .X_MIN(XMIN), .X_MAX(XMAX), .X_START(XSTART), .STEP(STEP)
  ) dut (
    .clk(clk), .reset(reset), .left(left), .right(right), .frame_tick(frame_tick),
    .draw_ack(draw_ack), .x_pos(x_pos), .draw_req(draw_req), .erase(erase),
    .busy(busy), .dir(dir)
  );

  player_motion_ctrl #(
    .X_W(X_W), .X_MIN(XMIN), .X_MAX(XMAX), .X_START(149), .STEP(STEP)
  ) dut_edge (
    .clk(clk), .reset(reset), .left(e_left), .right(e_right), .frame_tick(e_tick),
    .draw_ack(e_ack), .x_pos(e_x), .draw_req(e_req), .erase(e_erase),
    .busy(e_busy), .dir(e_dir)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference: one step toward the key, saturated at the playfield edge.
  function automatic int model_step(int x, bit go_right);
    int nx;
    if (go_right) begin
      nx = x + STEP;
      if (nx > XMAX) nx = XMAX;
    end else begin
      nx = x - STEP;
      if (nx < XMIN) nx = XMIN;
    end
    return nx;
  endfunction

  // Issue one frame tick with the given keys and queue the renderer traffic it should cause.
  task automatic issue(input bit l, input bit r, input int hold_e, input int hold_d);
    exp_t it;
    bit   go, d;
    left = l;
    right = r;
    frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    go = 1'b0;
    d  = 1'b0;
    if (l && !r && model_x > XMIN) begin
      go = 1'b1; d = 1'b0;
    end else if (r && !l && model_x < XMAX) begin
      go = 1'b1; d = 1'b1;
    end
    if (go) begin
      it.erase = 1'b1; it.x = model_x; it.d = d; it.hold = hold_e;
      sb_q.push_back(it);
      model_x   = model_step(model_x, d);
      model_dir = d;
      it.erase = 1'b0; it.x = model_x; it.d = d; it.hold = hold_d;
      sb_q.push_back(it);
    end
  endtask

  // Wait until every expected transaction is seen, then step past the final ack edge.
  task automatic wait_idle();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", sb_q.size(), 0);
    sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  // Renderer model: acks after a chosen delay, toggles ack randomly while no request is pending.
  initial begin
    draw_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!draw_req) begin
        draw_ack = 1'($urandom_range(0, 1));
        ack_cnt  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end else if (ack_cnt == 0) begin
        draw_ack = 1'b1;
      end else begin
        draw_ack = 1'b0;
        ack_cnt--;
      end
    end
  end

  // Monitor: every accepted request is popped from the scoreboard and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        run = 0;
      end else begin
        if (draw_req) run++;
        else run = 0;
        if (draw_req && draw_ack) begin
          tests++;
          if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_req: erase=%0d x_pos=%0d, expected no request", erase, x_pos);
          end else begin
            e = sb_q.pop_front();
            chk(e.erase ? "erase_order" : "draw_order", 32'(erase), 32'(e.erase));
            chk(e.erase ? "erase_x" : "draw_x", 32'(x_pos), e.x);
            chk(e.erase ? "erase_dir" : "draw_dir", 32'(dir), 32'(e.d));
            if (e.hold > 0) chk("req_hold_cycles", run, e.hold);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    fails++;
    summary();
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by biased random moves.
  initial begin
    reset = 1'b1;
    left = 1'b0; right = 1'b0; frame_tick = 1'b0;
    e_left = 1'b0; e_right = 1'b0; e_tick = 1'b0; e_ack = 1'b1;
    model_x = XSTART;
    model_dir = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x_pos", 32'(x_pos), XSTART);
    chk("rst_dir", 32'(dir), 0);
    chk("rst_draw_req", 32'(draw_req), 0);
    chk("rst_erase", 32'(erase), 0);
    chk("rst_busy", 32'(busy), 1);

    // Release: initial draw one cycle later, single-cycle request with immediate ack.
    fixed_delay = 0;
    begin
      exp_t it;
      it.erase = 1'b0; it.x = XSTART; it.d = 1'b0; it.hold = 1;
      sb_q.push_back(it);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("release_req_c0", 32'(draw_req), 0);
    @(negedge clk);
    chk("release_req_c1", 32'(draw_req), 1);
    wait_idle();
    chk("init_idle_busy", 32'(busy), 0);
    fixed_delay = -1;

    // Right edge clamp on the second instance, which starts at 149.
    chk("edge_busy_pre", 32'(e_busy), 0);
    e_right = 1'b1;
    @(posedge clk); #1 e_tick = 1'b1;
    @(posedge clk); #1 e_tick = 1'b0;
    ne = 0; nd = 0; ex = -1; dx = -1;
    repeat (8) @(negedge clk) begin
      if (e_req && e_erase) begin ne++; ex = 32'(e_x); end
      if (e_req && !e_erase) begin nd++; dx = 32'(e_x); end
    end
    chk("edge_erase_count", ne, 1);
    chk("edge_erase_x", ex, 149);
    chk("edge_draw_count", nd, 1);
    chk("edge_draw_x", dx, XMAX);
    chk("edge_dir", 32'(e_dir), 1);
    @(posedge clk); #1 e_tick = 1'b1;
    @(posedge clk); #1 e_tick = 1'b0;
    nd = 0;
    repeat (8) @(negedge clk) if (e_req) nd++;
    chk("edge_at_max_reqs", nd, 0);
    chk("edge_at_max_x", 32'(e_x), XMAX);
    e_right = 1'b0;

    // Three right moves: 76 -> 80 -> 84 -> 88.
    for (int i = 0; i < 3; i++) begin
      chk("busy_before_tick", 32'(busy), 0);
      issue(1'b0, 1'b1, 0, 0);
      wait_idle();
    end
    chk("three_right_x", 32'(x_pos), 88);

    // Both keys: no request, position held.
    issue(1'b1, 1'b1, 0, 0);
    repeat (6) @(negedge clk);
    chk("both_keys_x", 32'(x_pos), model_x);
    chk("both_keys_busy", 32'(busy), 0);
    wait_idle();

    // Slow renderer with a tick arriving mid-erase: request held 10 cycles, tick dropped.
    fixed_delay = 9;
    issue(1'b0, 1'b1, 10, 10);
    repeat (4) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    chk("slow_single_move_x", 32'(x_pos), model_x);
    wait_idle();

    // Minimum move latency with immediate acks.
    fixed_delay = 0;
    issue(1'b1, 1'b0, 1, 1);
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("move_cost_cycles", n + 2, 6);
    wait_idle();
    fixed_delay = -1;

    // Biased random walk: drift left, then right, then unbiased.
    for (int it = 0; it < 170; it++) begin
      pick = int'($urandom_range(0, 9));
      if (it < 60)       begin pl = 1'b1; pr = 1'b0; end
      else if (it < 130) begin pl = 1'b0; pr = 1'b1; end
      else               begin pl = 1'($urandom_range(0, 1)); pr = ~pl; end
      if (pick >= 7 && pick < 8)  begin pl = ~pl; pr = ~pr; end
      else if (pick == 8)         begin pl = 1'b1; pr = 1'b1; end
      else if (pick == 9)         begin pl = 1'b0; pr = 1'b0; end
      if ($urandom_range(0, 9) < 8) begin
        issue(pl, pr, 0, 0);
        if (sb_q.size() != 0 && $urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          left = 1'($urandom_range(0, 1));
          right = 1'($urandom_range(0, 1));
          frame_tick = 1'b1;
          @(posedge clk);
          #1 frame_tick = 1'b0;
        end
      end else begin
        left = pl; right = pr;
        repeat (3) @(posedge clk);
        #1;
      end
      wait_idle();
      chk("rand_x_pos", 32'(x_pos), model_x);
    end

    // Reset while a draw request is outstanding.
    fixed_delay = 20;
    if (model_x > XMIN) issue(1'b1, 1'b0, 0, 0);
    else issue(1'b0, 1'b1, 0, 0);
    n = 0;
    while (!(draw_req && !erase) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_draw_state", 32'(draw_req && !erase), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_draw_req", 32'(draw_req), 0);
    chk("midrst_x_pos", 32'(x_pos), XSTART);
    chk("midrst_dir", 32'(dir), 0);
    chk("midrst_busy", 32'(busy), 1);
    sb_q.delete();
    model_x = XSTART;
    model_dir = 1'b0;
    fixed_delay = 0;
    begin
      exp_t it;
      it.erase = 1'b0; it.x = XSTART; it.d = 1'b0; it.hold = 1;
      sb_q.push_back(it);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_idle();
    chk("post_rst_busy", 32'(busy), 0);

    repeat (5) @(negedge clk);
    chk("sb_empty_end", sb_q.size(), 0);
    summary();
    $finish;
  end

endmodule
